// File: rtl/tbird_pkg.sv
// Shared types, default parameters and counter-width helper for the
// T-bird tail-light front-end controller.
package tbird_pkg;

   // Arbitrated command state; exactly one of LEFT/RIGHT/HAZ drives tbird_fsm.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2,
      HAZ   = 2'd3
   } ctrl_state_t;

   localparam int DEF_DEBOUNCE_CYC = 4;
   localparam int DEF_TICK_DIV     = 8;
   localparam int DEF_SEQ_STEPS    = 4;

   // Bits needed to hold a counter running 0..max_val (never less than one bit).
   function automatic int cnt_width(input int max_val);
      int w;
      if (max_val < 1) begin
         w = 1;
      end else begin
         w = $clog2(max_val + 1);
      end
      return w;
   endfunction

   localparam int DEF_TICK_W = cnt_width(DEF_TICK_DIV - 1);
   localparam int DEF_STEP_W = cnt_width(DEF_SEQ_STEPS - 1);
   localparam int DEF_DEB_W  = cnt_width(DEF_DEBOUNCE_CYC - 1);

endpackage

// File: rtl/tbird_signal_ctrl_if.sv
// Driver-control and command bundle between the dash controls and the
// tail-light controller.
interface tbird_signal_ctrl_if;
   logic lever_left_i;
   logic lever_right_i;
   logic haz_btn_i;
   logic step_tick_o;
   logic left_o;
   logic right_o;
   logic haz_o;
   logic haz_latched_o;

   // Control source side: drives the raw driver inputs, observes commands.
   modport master (
      output lever_left_i, lever_right_i, haz_btn_i,
      input  step_tick_o, left_o, right_o, haz_o, haz_latched_o
   );

   // Controller side: consumes raw inputs, produces commands.
   modport slave (
      input  lever_left_i, lever_right_i, haz_btn_i,
      output step_tick_o, left_o, right_o, haz_o, haz_latched_o
   );
endinterface

// File: rtl/tbird_debounce.sv
// Two-flop synchronizer followed by a consecutive-sample debouncer.
// A raw change appears on filt_o 2+DEBOUNCE_CYC clocks later; shorter
// pulses never reach the output.
module tbird_debounce
   import tbird_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC
) (
   input  logic clk,
   input  logic rst_b,
   input  logic raw_i,
   output logic filt_o
);

   localparam int               CNT_W    = cnt_width(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic             sync1_r;
   logic             sync2_r;
   logic             filt_r;
   logic [CNT_W-1:0] cnt_r;

   // Bring the asynchronous raw input into the clock domain.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
      end else begin
         sync1_r <= raw_i;
         sync2_r <= sync1_r;
      end
   end

   // Accept the synchronized value only after DEBOUNCE_CYC consecutive differing samples.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         cnt_r  <= CNT_ZERO;
         filt_r <= 1'b0;
      end else if (sync2_r != filt_r) begin
         if (cnt_r == CNT_LAST) begin
            filt_r <= sync2_r;
            cnt_r  <= CNT_ZERO;
         end else begin
            cnt_r  <= cnt_r + CNT_ONE;
         end
      end else begin
         cnt_r <= CNT_ZERO;
      end
   end

   assign filt_o = filt_r;

endmodule

// File: rtl/tbird_signal_ctrl.sv
// Front-end for tbird_fsm: conditions the turn lever and hazard button,
// keeps the hazard toggle, paces the sequence with step_tick and
// arbitrates one mutually exclusive command with a minimum turn hold.
module tbird_signal_ctrl
   import tbird_pkg::*;
#(
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int TICK_DIV     = DEF_TICK_DIV,
   parameter int SEQ_STEPS    = DEF_SEQ_STEPS
) (
   input  logic               clk,
   input  logic               rst_b,
   tbird_signal_ctrl_if.slave bus
);

   localparam int                TICK_W      = cnt_width(TICK_DIV - 1);
   localparam int                STEP_W      = cnt_width(SEQ_STEPS - 1);
   localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(TICK_DIV - 1);
   localparam logic [TICK_W-1:0] TICK_ONE    = TICK_W'(1);
   localparam logic [TICK_W-1:0] TICK_ZERO   = TICK_W'(0);
   localparam logic [STEP_W-1:0] STEP_RELOAD = STEP_W'(SEQ_STEPS - 1);
   localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);
   localparam logic [STEP_W-1:0] STEP_ZERO   = STEP_W'(0);

   logic              fl_left_s;
   logic              fl_right_s;
   logic              fl_haz_s;
   logic              fl_haz_d_r;
   logic              haz_latched_r;
   logic [TICK_W-1:0] tick_cnt_r;
   logic              step_tick_s;
   ctrl_state_t       state_r;
   ctrl_state_t       state_nxt_s;
   logic [STEP_W-1:0] step_cnt_r;
   logic [STEP_W-1:0] step_nxt_s;
   logic              req_haz_s;
   logic              req_left_s;
   logic              req_right_s;

   tbird_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
      .clk    (clk),
      .rst_b  (rst_b),
      .raw_i  (bus.lever_left_i),
      .filt_o (fl_left_s)
   );

   tbird_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
      .clk    (clk),
      .rst_b  (rst_b),
      .raw_i  (bus.lever_right_i),
      .filt_o (fl_right_s)
   );

   tbird_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_haz (
      .clk    (clk),
      .rst_b  (rst_b),
      .raw_i  (bus.haz_btn_i),
      .filt_o (fl_haz_s)
   );

   // Toggle the hazard latch on each rising edge of the filtered button.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         fl_haz_d_r    <= 1'b0;
         haz_latched_r <= 1'b0;
      end else begin
         fl_haz_d_r <= fl_haz_s;
         if (fl_haz_s && !fl_haz_d_r) begin
            haz_latched_r <= ~haz_latched_r;
         end else begin
            haz_latched_r <= haz_latched_r;
         end
      end
   end

   // Free-running step divider, independent of the command state.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         tick_cnt_r <= TICK_ZERO;
      end else if (tick_cnt_r == TICK_LAST) begin
         tick_cnt_r <= TICK_ZERO;
      end else begin
         tick_cnt_r <= tick_cnt_r + TICK_ONE;
      end
   end

   assign step_tick_s = (tick_cnt_r == TICK_LAST);

   // Both levers at once is treated as no turn request.
   assign req_haz_s   = haz_latched_r;
   assign req_left_s  = fl_left_s & ~fl_right_s;
   assign req_right_s = fl_right_s & ~fl_left_s;

   // Next command: hazard wins, a granted turn is held until its steps run out.
   always_comb begin
      state_nxt_s = state_r;
      step_nxt_s  = step_cnt_r;
      case (state_r)
         LEFT, RIGHT: begin
            if (req_haz_s) begin
               state_nxt_s = HAZ;
            end else if (step_cnt_r != STEP_ZERO) begin
               step_nxt_s = step_cnt_r - STEP_ONE;
            end else if (req_left_s) begin
               state_nxt_s = LEFT;
               step_nxt_s  = STEP_RELOAD;
            end else if (req_right_s) begin
               state_nxt_s = RIGHT;
               step_nxt_s  = STEP_RELOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         IDLE, HAZ: begin
            if (req_haz_s) begin
               state_nxt_s = HAZ;
            end else if (req_left_s) begin
               state_nxt_s = LEFT;
               step_nxt_s  = STEP_RELOAD;
            end else if (req_right_s) begin
               state_nxt_s = RIGHT;
               step_nxt_s  = STEP_RELOAD;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         default: begin
            state_nxt_s = IDLE;
            step_nxt_s  = STEP_ZERO;
         end
      endcase
   end

   // Commit the arbitration only on step_tick edges so commands align with the sequence.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r    <= IDLE;
         step_cnt_r <= STEP_ZERO;
      end else if (step_tick_s) begin
         state_r    <= state_nxt_s;
         step_cnt_r <= step_nxt_s;
      end else begin
         state_r    <= state_r;
         step_cnt_r <= step_cnt_r;
      end
   end

   assign bus.step_tick_o   = step_tick_s;
   assign bus.left_o        = (state_r == LEFT);
   assign bus.right_o       = (state_r == RIGHT);
   assign bus.haz_o         = (state_r == HAZ);
   assign bus.haz_latched_o = haz_latched_r;

endmodule

// File: tb/tb_tbird_signal_ctrl.sv
// Directed bench for tbird_signal_ctrl with default parameters.
// Timeline is counted in rising edges since reset release (ecount);
// inputs change and outputs are observed 1 ns after a rising edge.
// Output vector order: {left_o, right_o, haz_o, haz_latched_o}.
module tb_tbird_signal_ctrl;

   logic clk;
   logic rst_b;
   int   checks;
   int   errors;
   int   ecount;
   logic [2:0] cmd_before;

   tbird_signal_ctrl_if bus ();

   tbird_signal_ctrl dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] outs();
      return {bus.left_o, bus.right_o, bus.haz_o, bus.haz_latched_o};
   endfunction

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s @edge %0d: observed %b expected %b", tag, ecount, obs, exp);
      end
   endtask

   task automatic step_to(input int target);
      while (ecount < target) begin
         @(posedge clk);
         #1;
         ecount++;
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      ecount = 0;
      rst_b  = 1'b0;
      bus.lever_left_i  = 1'b0;
      bus.lever_right_i = 1'b0;
      bus.haz_btn_i     = 1'b0;

      // Reset state
      #22;
      check("reset_outs", outs(), 4'b0000);
      check("reset_tick", {3'b000, bus.step_tick_o}, 4'b0000);
      #5;
      rst_b = 1'b1;

      // First tick after 7 edges, then every 8
      for (int i = 1; i <= 15; i++) begin
         step_to(i);
         check("tick_phase", {3'b000, bus.step_tick_o}, {3'b000, (i == 7 || i == 15)});
      end

      // Left lever: grant on tick edge 24, held 4 ticks after release
      step_to(16);
      bus.lever_left_i = 1'b1;
      step_to(23); check("left_pre", outs(), 4'b0000);
      step_to(24); check("left_grant", outs(), 4'b1000);
      bus.lever_left_i = 1'b0;
      step_to(40); check("left_hold", outs(), 4'b1000);
      step_to(55); check("left_hold_last", outs(), 4'b1000);
      step_to(56); check("left_done", outs(), 4'b0000);

      // Glitch rejection: 3-clock pulses on right lever and hazard button
      bus.lever_right_i = 1'b1;
      bus.haz_btn_i     = 1'b1;
      step_to(59);
      bus.lever_right_i = 1'b0;
      bus.haz_btn_i     = 1'b0;
      for (int i = 60; i <= 96; i++) begin
         step_to(i);
         check("glitch_quiet", outs(), 4'b0000);
      end

      // Hazard preempts RIGHT at step 1, toggling off returns to held lever
      bus.lever_right_i = 1'b1;
      step_to(104); check("right_grant", outs(), 4'b0100);
      step_to(120);
      bus.haz_btn_i = 1'b1;
      step_to(127); check("haz_latch_on", outs(), 4'b0101);
      step_to(128); check("haz_preempt", outs(), 4'b0011);
      step_to(130);
      bus.haz_btn_i = 1'b0;
      step_to(136);
      bus.haz_btn_i = 1'b1;
      step_to(143); check("haz_latch_off", outs(), 4'b0010);
      step_to(144); check("haz_to_right", outs(), 4'b0100);
      bus.lever_right_i = 1'b0;
      step_to(146);
      bus.haz_btn_i = 1'b0;
      step_to(175); check("right_hold_last", outs(), 4'b0100);
      step_to(176); check("right_done", outs(), 4'b0000);

      // Both levers: no command for 5 ticks
      bus.lever_left_i  = 1'b1;
      bus.lever_right_i = 1'b1;
      for (int i = 177; i <= 216; i++) begin
         step_to(i);
         check("both_levers", outs(), 4'b0000);
      end

      // Left only, reversed at step 2: full 4-tick hold then RIGHT
      bus.lever_right_i = 1'b0;
      step_to(223); check("left2_pre", outs(), 4'b0000);
      step_to(224); check("left2_grant", outs(), 4'b1000);
      step_to(232);
      bus.lever_left_i  = 1'b0;
      bus.lever_right_i = 1'b1;
      step_to(255); check("reverse_hold", outs(), 4'b1000);
      step_to(256); check("reverse_right", outs(), 4'b0100);
      bus.lever_right_i = 1'b0;
      step_to(287); check("right2_hold", outs(), 4'b0100);
      step_to(288); check("right2_done", outs(), 4'b0000);

      // Hazard on and off with no lever: HAZ then IDLE
      bus.haz_btn_i = 1'b1;
      step_to(295); check("haz2_latch", outs(), 4'b0001);
      step_to(296); check("haz2_on", outs(), 4'b0011);
      step_to(298);
      bus.haz_btn_i = 1'b0;
      step_to(304);
      bus.haz_btn_i = 1'b1;
      step_to(311); check("haz2_unlatch", outs(), 4'b0010);
      step_to(312); check("haz2_idle", outs(), 4'b0000);
      bus.haz_btn_i = 1'b0;

      // Reset mid-LEFT clears outputs immediately
      bus.lever_left_i = 1'b1;
      step_to(320); check("left3_grant", outs(), 4'b1000);
      step_to(322);
      #3;
      rst_b = 1'b0;
      bus.lever_left_i = 1'b0;
      #1;
      check("async_reset", outs(), 4'b0000);
      check("async_reset_tick", {3'b000, bus.step_tick_o}, 4'b0000);
      #10;
      rst_b  = 1'b1;
      ecount = 0;
      for (int i = 1; i <= 8; i++) begin
         step_to(i);
         check("tick_after_reset", {bus.step_tick_o, bus.left_o, bus.right_o, bus.haz_o},
               {(i == 7), 3'b000});
      end

      // Random raw stream: exclusivity and state changes only on tick edges
      for (int i = 0; i < 5000; i++) begin
         cmd_before = {bus.left_o, bus.right_o, bus.haz_o};
         if ($urandom_range(0, 19) == 0) bus.lever_left_i  = ~bus.lever_left_i;
         if ($urandom_range(0, 19) == 0) bus.lever_right_i = ~bus.lever_right_i;
         if ($urandom_range(0, 29) == 0) bus.haz_btn_i     = ~bus.haz_btn_i;
         step_to(ecount + 1);
         check("onehot0", {3'b000, $onehot0({bus.left_o, bus.right_o, bus.haz_o})}, 4'b0001);
         if ((ecount % 8) != 0) begin
            check("no_change_off_tick", {1'b0, bus.left_o, bus.right_o, bus.haz_o},
                  {1'b0, cmd_before});
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tbird_signal_ctrl.md
Name: tbird_signal_ctrl

Overview:
- Front-end controller for tbird_fsm.
- Conditions the raw driver controls: turn lever left/right and a momentary hazard button.
- Arbitrates them into one registered, mutually exclusive command (left/right/haz) that drives tbird_fsm inputs directly.
- Generates the step_tick that paces the light sequence, and guarantees a granted turn is held for a minimum number of steps so the tail-light sequence is never truncated.

Parameters:
- DEBOUNCE_CYC, 4: consecutive clocks a synchronized input must differ from its filtered value before the filtered value updates.
- TICK_DIV, 8: clocks per step_tick period. Legal range is ≥2.
- SEQ_STEPS, 4: minimum step_ticks a LEFT/RIGHT grant is held.

Ports:
- clk  input  1  system clock, rising edge
- rst_b  input  1  asynchronous active-low reset
- lever_left_i  input  1  raw, asynchronous turn lever left
- lever_right_i  input  1  raw, asynchronous turn lever right
- haz_btn_i  input  1  raw, asynchronous momentary hazard button
- step_tick_o  output  1  one-clock pulse every TICK_DIV clocks
- left_o  output  1  command to tbird_fsm left
- right_o  output  1  command to tbird_fsm right
- haz_o  output  1  command to tbird_fsm haz
- haz_latched_o  output  1  current hazard toggle state, for a dash indicator

Behaviour:
- Reset
  - rst_b low asynchronously clears all flops and forces all outputs to 0 immediately.
  - This includes the synchronizers, debounce counters, filtered values, haz latch, tick counter, step counter and state (IDLE).
  - Reset mid-grant aborts the grant with no completion.
- Input conditioning, per input
  - 2-flop synchronizer feeds the debouncer.
  - Counter increments each clock sync≠filtered and clears when they are equal.
  - On the DEBOUNCE_CYC-th consecutive differing sample, filtered takes the sync value and the counter clears.
  - A raw change reaches filtered after 2+DEBOUNCE_CYC clocks. Pulses shorter than DEBOUNCE_CYC clocks are rejected.
- Hazard latch
  - A rising edge of filtered haz_btn toggles haz_latched (registered, 1-clock edge detect).
  - A falling edge has no effect.
- Tick
  - tick_cnt counts 0..TICK_DIV-1 and wraps; free-running, independent of state.
  - step_tick_o = (tick_cnt == TICK_DIV-1).
  - After reset release, the first tick is high during the 8th clock (after 7 edges, defaults).
- State machine (enum IDLE, LEFT, RIGHT, HAZ)
  - State updates only on edges where step_tick_o=1. Outputs are decoded from the state register: left_o=LEFT, right_o=RIGHT, haz_o=HAZ.
  - At most one command is ever high.
  - Request decode:
    - req_haz = haz_latched.
    - req_left = fl_left & ~fl_right.
    - req_right = fl_right & ~fl_left.
    - Both levers high = no turn request.
  - Priority: haz > left > right.
  - IDLE: req_haz→HAZ; else req_left→LEFT (step_cnt=SEQ_STEPS-1); else req_right→RIGHT (step_cnt=SEQ_STEPS-1); else stay.
  - LEFT/RIGHT:
    - req_haz→HAZ immediately, preempting the hold.
    - Else if step_cnt≠0: decrement and stay, even if the lever is released or reversed.
    - Else (step_cnt=0): same request→stay (step_cnt reloads SEQ_STEPS-1); opposite request→opposite state (reload); none→IDLE.
  - HAZ: stays while req_haz. On clear, next state is chosen by the IDLE rules in the same tick, so a lever held during hazard goes directly to LEFT/RIGHT.
- Simultaneous events
  - A haz toggle and a lever change in the same tick resolve by priority.
  - The haz latch toggling off and back on between ticks produces no state change.

Decomposition:
- Package tbird_pkg:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, LEFT, RIGHT, HAZ}.
  - Width localparams via $clog2 for tick_cnt, step_cnt and debounce counters.
- Sub-module tbird_debounce (synchronizer + debouncer, params DEBOUNCE_CYC, ports clk, rst_b, raw_i, filt_o).
  - Instantiated 3x.
- Top holds the haz latch, tick divider and FSM.

Test Plan:
1. Reset: assert rst_b=0 mid-LEFT, between clock edges → all outputs 0 immediately. Release → first step_tick_o high after 7 rising edges, then every 8 clocks.
2. Lever left held (defaults) → left_o rises on the first tick edge ≥6 clocks after raw rise. Release after 1 tick → left_o stays high exactly 4 ticks total, then IDLE.
3. Glitch rejection: lever_right_i pulsed high for 3 clocks, and haz_btn_i for 3 clocks → no output or haz_latched_o change for 40 clocks.
4. Preempt: in RIGHT at step 1, press haz_btn_i for 10 clocks → haz_latched_o=1, and haz_o=1/right_o=0 on the next tick edge. Press again → haz_latched_o=0; next tick IDLE, or RIGHT if the lever is still held.
5. Both levers high from IDLE → no command for 5 ticks. Left held, then switched to right at step 2 → left_o holds to 4 ticks, then right_o on the following tick.
6. Exclusivity assertion over a random raw-input stream of 5000 clocks → $onehot0({left_o,right_o,haz_o}) always holds, and state changes occur only on step_tick edges.
